// File: rtl/scan_mux.sv
// N_CH:1 channel multiplexer with registered output, manual select or
// round-robin scan with a programmable per-channel dwell.
module scan_mux #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   x,
  input  logic [SEL_W-1:0]        s,
  input  logic                    mode,
  input  logic                    en,
  output logic [WIDTH-1:0]        o,
  output logic [SEL_W-1:0]        ch,
  output logic                    v,
  output logic                    err,
  output logic                    wrap
);

  localparam int unsigned DW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, cur_ptr;
  logic [DW-1:0]    dcnt, dcnt_nxt, cur_dcnt;
  logic [WIDTH-1:0] o_nxt;
  logic [SEL_W-1:0] ch_nxt;
  logic             v_nxt, err_nxt, wrap_nxt;
  logic             s_ok, ptr_last, dwell_done;

  // Loop-based pick keeps out-of-range indices from reaching an array select.
  function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] xin,
                                            input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r = xin[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (en) state_nxt = mode ? SCAN : MAN;
  end

  // Compares widened to 32 bits so N_CH == 2**SEL_W cannot wrap to zero.
  always_comb begin
    cur_ptr    = (state == MAN) ? '0 : ptr;
    cur_dcnt   = (state == MAN) ? '0 : dcnt;
    s_ok       = 32'(s) < N_CH;
    ptr_last   = 32'(cur_ptr) == (N_CH - 1);
    dwell_done = cur_dcnt == DW'(DWELL - 1);

    o_nxt    = o;
    ch_nxt   = ch;
    v_nxt    = 1'b0;
    err_nxt  = 1'b0;
    wrap_nxt = 1'b0;
    ptr_nxt  = ptr;
    dcnt_nxt = dcnt;

    case (state_nxt)
      MAN: begin
        ptr_nxt  = '0;
        dcnt_nxt = '0;
        if (s_ok) begin
          o_nxt  = pick(x, s);
          ch_nxt = s;
          v_nxt  = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      SCAN: begin
        o_nxt  = pick(x, cur_ptr);
        ch_nxt = cur_ptr;
        v_nxt  = 1'b1;
        if (dwell_done) begin
          dcnt_nxt = '0;
          if (ptr_last) begin
            ptr_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            ptr_nxt = cur_ptr + SEL_W'(1);
          end
        end else begin
          dcnt_nxt = cur_dcnt + DW'(1);
          ptr_nxt  = cur_ptr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o    <= '0;
      ch   <= '0;
      v    <= 1'b0;
      err  <= 1'b0;
      wrap <= 1'b0;
      ptr  <= '0;
      dcnt <= '0;
    end else begin
      o    <= o_nxt;
      ch   <= ch_nxt;
      v    <= v_nxt;
      err  <= err_nxt;
      wrap <= wrap_nxt;
      ptr  <= ptr_nxt;
      dcnt <= dcnt_nxt;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: three instances cover DWELL=2, DWELL=1
// and a non-power-of-two channel count.
module tb_scan_mux;

  logic        clk, rst;
  logic [31:0] x4;
  logic [23:0] x3;

  logic [1:0] a_s, b_s, c_s;
  logic       a_mode, b_mode, c_mode, a_en, b_en, c_en;
  logic [7:0] a_o, b_o, c_o;
  logic [1:0] a_ch, b_ch, c_ch;
  logic       a_v, b_v, c_v, a_err, b_err, c_err, a_wrap, b_wrap, c_wrap;

  int n_cmp = 0;
  int n_err = 0;

  scan_mux #(.N_CH(4), .WIDTH(8), .SEL_W(2), .DWELL(2)) u_a (
    .clk(clk), .rst(rst), .x(x4), .s(a_s), .mode(a_mode), .en(a_en),
    .o(a_o), .ch(a_ch), .v(a_v), .err(a_err), .wrap(a_wrap));

  scan_mux #(.N_CH(4), .WIDTH(8), .SEL_W(2), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .x(x4), .s(b_s), .mode(b_mode), .en(b_en),
    .o(b_o), .ch(b_ch), .v(b_v), .err(b_err), .wrap(b_wrap));

  scan_mux #(.N_CH(3), .WIDTH(8), .SEL_W(2), .DWELL(1)) u_c (
    .clk(clk), .rst(rst), .x(x3), .s(c_s), .mode(c_mode), .en(c_en),
    .o(c_o), .ch(c_ch), .v(c_v), .err(c_err), .wrap(c_wrap));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] ech;
    rst = 1'b1;
    x4 = 32'h44332211;
    x3 = 24'h332211;
    a_s = 2'd0; b_s = 2'd0; c_s = 2'd0;
    a_mode = 1'b0; b_mode = 1'b0; c_mode = 1'b0;
    a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_o",    32'(a_o), 32'h0);
    check("rst_ch",   32'(a_ch), 32'h0);
    check("rst_v",    32'(a_v), 32'h0);
    check("rst_err",  32'(a_err), 32'h0);
    check("rst_wrap", 32'(a_wrap), 32'h0);
    rst = 1'b0;

    // manual select
    a_en = 1'b1; a_mode = 1'b0; a_s = 2'd2;
    @(negedge clk);
    check("man_s2_o",  32'(a_o), 32'h33);
    check("man_s2_ch", 32'(a_ch), 32'd2);
    check("man_s2_v",  32'(a_v), 32'd1);
    check("man_s2_err", 32'(a_err), 32'd0);
    a_s = 2'd3;
    @(negedge clk);
    check("man_s3_o",  32'(a_o), 32'h44);
    check("man_s3_err", 32'(a_err), 32'd0);
    a_s = 2'd0;
    @(negedge clk);
    check("man_s0_o",  32'(a_o), 32'h11);
    check("man_s0_ch", 32'(a_ch), 32'd0);

    // asynchronous reset away from any edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_o",  32'(a_o), 32'h0);
    check("async_rst_ch", 32'(a_ch), 32'h0);
    check("async_rst_v",  32'(a_v), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // scan DWELL=2 from reset: ch = 0,0,1,1,2,2,3,3,0,0,1,1,2
    a_mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ech = 2'((i / 2) % 4);
      check($sformatf("scan2_ch[%0d]", i), 32'(a_ch), 32'(ech));
      check($sformatf("scan2_o[%0d]", i), 32'(a_o), 32'h11 * (32'(ech) + 1));
      check($sformatf("scan2_wrap[%0d]", i), 32'(a_wrap), (i == 7) ? 32'd1 : 32'd0);
      check($sformatf("scan2_v[%0d]", i), 32'(a_v), 32'd1);
    end

    // reset mid-dwell at ch=2, then full restart from ch 0
    #1 rst = 1'b1;
    #1;
    check("mid_rst_o",  32'(a_o), 32'h0);
    check("mid_rst_ch", 32'(a_ch), 32'h0);
    check("mid_rst_v",  32'(a_v), 32'h0);
    check("mid_rst_wrap", 32'(a_wrap), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_ch0a", 32'(a_ch), 32'd0);
    check("restart_v",    32'(a_v), 32'd1);
    @(negedge clk);
    check("restart_ch0b", 32'(a_ch), 32'd0);
    @(negedge clk);
    check("restart_ch1",  32'(a_ch), 32'd1);
    check("restart_o",    32'(a_o), 32'h22);
    a_en = 1'b0;

    // scan DWELL=1 with a 3-cycle enable gap at ch=1
    b_en = 1'b1; b_mode = 1'b1;
    @(negedge clk);
    check("gap_ch0", 32'(b_ch), 32'd0);
    @(negedge clk);
    check("gap_ch1", 32'(b_ch), 32'd1);
    check("gap_o1",  32'(b_o), 32'h22);
    b_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("gap_hold_v[%0d]", i), 32'(b_v), 32'd0);
      check($sformatf("gap_hold_o[%0d]", i), 32'(b_o), 32'h22);
      check($sformatf("gap_hold_ch[%0d]", i), 32'(b_ch), 32'd1);
    end
    b_en = 1'b1;
    @(negedge clk);
    check("resume_ch2", 32'(b_ch), 32'd2);
    check("resume_o",   32'(b_o), 32'h33);
    check("resume_v",   32'(b_v), 32'd1);
    @(negedge clk);
    check("resume_ch3",  32'(b_ch), 32'd3);
    check("resume_wrap", 32'(b_wrap), 32'd1);
    // en=0 overrides a mode change; mode switch to manual applies with en
    b_en = 1'b0; b_mode = 1'b0; b_s = 2'd1;
    @(negedge clk);
    check("override_v", 32'(b_v), 32'd0);
    check("override_wrap", 32'(b_wrap), 32'd0);
    b_en = 1'b1;
    @(negedge clk);
    check("en_man_o",  32'(b_o), 32'h22);
    check("en_man_ch", 32'(b_ch), 32'd1);

    // N_CH=3: out-of-range select
    c_en = 1'b1; c_mode = 1'b0; c_s = 2'd2;
    @(negedge clk);
    check("n3_s2_o", 32'(c_o), 32'h33);
    check("n3_s2_v", 32'(c_v), 32'd1);
    c_s = 2'd3;
    @(negedge clk);
    check("n3_s3_err", 32'(c_err), 32'd1);
    check("n3_s3_v",   32'(c_v), 32'd0);
    check("n3_s3_o",   32'(c_o), 32'h33);
    check("n3_s3_ch",  32'(c_ch), 32'd2);
    check("n3_s3_wrap", 32'(c_wrap), 32'd0);
    c_s = 2'd1;
    @(negedge clk);
    check("n3_s1_err", 32'(c_err), 32'd0);
    check("n3_s1_v",   32'(c_v), 32'd1);
    check("n3_s1_o",   32'(c_o), 32'h22);

    // N_CH=3 scan wraps after channel 2
    c_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ech = 2'(i % 3);
      check($sformatf("n3_scan_ch[%0d]", i), 32'(c_ch), 32'(ech));
      check($sformatf("n3_scan_wrap[%0d]", i), 32'(c_wrap), (i == 2) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
